// File: rtl/gate_table_checker_if.sv
// Result-record stream of the gate-table checker: one record per input row,
// transferred on row_valid & row_ready.
interface gate_table_checker_if;
    logic       row_valid;
    logic       row_ready;
    logic [8:0] row_data;
    logic [6:0] row_err;

    modport master (
        output row_valid,
        output row_data,
        output row_err,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_data,
        input  row_err,
        output row_ready
    );
endinterface

// File: rtl/gate_table_checker.sv
// Self-test driver and monitor for a two-input basic-gate unit.
// Sweeps AB = 00, 01, 10, 11, lets each row settle, samples the seven gate
// outputs, compares them to locally computed truth values and streams one
// record per row, then reports an overall pass/fail and a failing-row count.
module gate_table_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        a_out,
    output logic                        b_out,
    input  logic [6:0]                  dut_y,
    gate_table_checker_if.master        row,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_out_q, a_out_d;
    logic       b_out_q, b_out_d;
    logic [8:0] row_data_q, row_data_d;
    logic [6:0] row_err_q, row_err_d;
    logic [2:0] err_count_q, err_count_d;
    logic       pass_q, pass_d;
    logic [6:0] expected;
    logic [6:0] mismatch;

    // State and datapath registers; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_out_q     <= 1'b0;
            b_out_q     <= 1'b0;
            row_data_q  <= '0;
            row_err_q   <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            row_data_q  <= row_data_d;
            row_err_q   <= row_err_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state sequencing through drive, settle, sample and emit per row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
            ST_SETTLE: if (cnt_q <= 4'd1) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_EMIT;
            ST_EMIT:   if (row.row_ready) state_d = (idx_q == 2'd3) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Truth values {NOT A, XNOR, NOR, NAND, XOR, OR, AND} of the driven row.
    always_comb begin
        expected = {~a_out_q, ~(a_out_q ^ b_out_q), ~(a_out_q | b_out_q),
                    ~(a_out_q & b_out_q), a_out_q ^ b_out_q,
                    a_out_q | b_out_q, a_out_q & b_out_q};
        mismatch = dut_y ^ expected;
    end

    // Datapath updates: stimulus, settle count, record capture and tallies.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        row_data_d  = row_data_q;
        row_err_d   = row_err_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE: begin
                a_out_d = 1'b0;
                b_out_d = 1'b0;
                if (start) begin
                    idx_d       = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_DRIVE: begin
                a_out_d = idx_q[1];
                b_out_d = idx_q[0];
                cnt_d   = SETTLE_CNT;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_SAMPLE: begin
                row_data_d = {a_out_q, b_out_q, dut_y};
                row_err_d  = mismatch;
                if (|mismatch) err_count_d = err_count_q + 3'd1;
            end
            ST_EMIT: begin
                if (row.row_ready && idx_q != 2'd3) idx_d = idx_q + 2'd1;
            end
            ST_DONE: begin
                pass_d  = (err_count_q == 3'd0);
                a_out_d = 1'b0;
                b_out_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Status and handshake outputs decoded from the current state.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        row.row_valid = (state_q == ST_EMIT);
    end

    assign a_out        = a_out_q;
    assign b_out        = b_out_q;
    assign row.row_data = row_data_q;
    assign row.row_err  = row_err_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;

endmodule
